// File: rtl/tdc_meas_ctrl.sv
// Single-shot TDC measurement sequencer: arms start/stop filters in turn, counts coarse cycles,
// merges fine bin codes into a signed interval and holds it behind a valid/ready handshake.
module tdc_meas_ctrl #(
  parameter int unsigned COARSE_W     = 16,
  parameter int unsigned FINE_W       = 8,
  parameter int unsigned BINS_PER_CLK = 200,
  parameter int unsigned TIMEOUT_CYC  = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         auto_rearm,
  input  logic                         start_evt,
  input  logic [FINE_W-1:0]            start_fine,
  input  logic                         stop_evt,
  input  logic [FINE_W-1:0]            stop_fine,
  output logic                         en_start,
  output logic                         en_stop,
  output logic                         busy,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [COARSE_W+FINE_W+1:0]   res_interval,
  output logic [COARSE_W-1:0]          res_coarse,
  output logic                         res_timeout,
  output logic [7:0]                   missed_cnt
);

  localparam int unsigned IW = COARSE_W + FINE_W + 2;

  typedef enum logic [1:0] {StIdle, StArmed, StRunning, StDone} state_e;

  state_e              state_q, state_d;
  logic [COARSE_W-1:0] cnt_q, cnt_d;
  logic [FINE_W-1:0]   start_fine_q, start_fine_d;
  logic                capture, timeout_hit;
  logic [IW-1:0]       interval_calc;

  logic                en_start_q, en_stop_q, busy_q, res_valid_q, res_timeout_q;
  logic [IW-1:0]       res_interval_q;
  logic [COARSE_W-1:0] res_coarse_q;
  logic [7:0]          missed_q;

  // Two's complement wrap at full output width gives the signed result directly.
  assign interval_calc = IW'(cnt_q) * IW'(BINS_PER_CLK) + IW'(start_fine_q) - IW'(stop_fine);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_fine_d = start_fine_q;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) state_d = StArmed;
        end
        StArmed: begin
          if (start_evt) begin
            start_fine_d = start_fine;
            // Counter holds cycles elapsed since the start edge, so the first RUNNING cycle is 1.
            cnt_d        = COARSE_W'(1);
            state_d      = StRunning;
          end
        end
        StRunning: begin
          cnt_d = cnt_q + COARSE_W'(1);
          if (stop_evt) begin
            capture = 1'b1;
            state_d = StDone;
          end else if (cnt_q == COARSE_W'(TIMEOUT_CYC)) begin
            capture     = 1'b1;
            timeout_hit = 1'b1;
            state_d     = StDone;
          end
        end
        StDone: begin
          if (res_ready) state_d = auto_rearm ? StArmed : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      start_fine_q   <= '0;
      en_start_q     <= 1'b0;
      en_stop_q      <= 1'b0;
      busy_q         <= 1'b0;
      res_valid_q    <= 1'b0;
      res_interval_q <= '0;
      res_coarse_q   <= '0;
      res_timeout_q  <= 1'b0;
      missed_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_fine_q <= start_fine_d;
      en_start_q   <= (state_d == StArmed);
      en_stop_q    <= (state_d == StRunning);
      busy_q       <= (state_d == StArmed) || (state_d == StRunning);
      res_valid_q  <= (state_d == StDone);
      if (capture) begin
        res_coarse_q   <= cnt_q;
        res_interval_q <= timeout_hit ? '0 : interval_calc;
        res_timeout_q  <= timeout_hit;
      end
      if (!abort && state_q == StDone && (start_evt || stop_evt) && missed_q != 8'hff) begin
        missed_q <= missed_q + 8'd1;
      end
    end
  end

  assign en_start     = en_start_q;
  assign en_stop      = en_stop_q;
  assign busy         = busy_q;
  assign res_valid    = res_valid_q;
  assign res_interval = res_interval_q;
  assign res_coarse   = res_coarse_q;
  assign res_timeout  = res_timeout_q;
  assign missed_cnt   = missed_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Bench for tdc_meas_ctrl: directed measurements, results checked by a queue-based scoreboard.
module tb_tdc_meas_ctrl;

  localparam int W = 26;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         arm = 1'b0, abort = 1'b0, auto_rearm = 1'b0;
  logic         start_evt = 1'b0, stop_evt = 1'b0;
  logic [7:0]   start_fine = '0, stop_fine = '0;
  logic         res_ready = 1'b0;
  logic         en_start, en_stop, busy, res_valid, res_timeout;
  logic [W-1:0] res_interval;
  logic [15:0]  res_coarse;
  logic [7:0]   missed_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0]  coarse;
    logic [W-1:0] interval;
    logic         timeout;
  } exp_t;
  exp_t exp_q[$];

  tdc_meas_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .auto_rearm   (auto_rearm),
    .start_evt    (start_evt),
    .start_fine   (start_fine),
    .stop_evt     (stop_evt),
    .stop_fine    (stop_fine),
    .en_start     (en_start),
    .en_stop      (en_stop),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_interval (res_interval),
    .res_coarse   (res_coarse),
    .res_timeout  (res_timeout),
    .missed_cnt   (missed_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int coarse, input int interval, input bit to);
    exp_t e;
    e.coarse   = 16'(coarse);
    e.interval = W'(interval);
    e.timeout  = to;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: compares every accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(res_coarse), 32'hffff_ffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_coarse", 32'(res_coarse), 32'(e.coarse));
        chk("res_interval", 32'(res_interval), 32'(e.interval));
        chk("res_timeout", 32'(res_timeout), 32'(e.timeout));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input logic [7:0] sf, input logic [7:0] pf, input int gap,
                         input bit dual);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    start_evt = 1'b1;
    start_fine = sf;
    stop_evt = dual;
    stop_fine = 8'd5;
    tick();
    start_evt = 1'b0;
    stop_evt = 1'b0;
    repeat (gap - 1) tick();
    stop_evt = 1'b1;
    stop_fine = pf;
    tick();
    stop_evt = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    bit stable;
    #2;
    chk("rst_en_start", 32'(en_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_interval", 32'(res_interval), 0);
    chk("rst_missed", 32'(missed_cnt), 0);
    #10;
    reset = 1'b0;
    tick();

    // Basic measurement: 3*200 + 150 - 40 = 710
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("en_start_after_arm", 32'(en_start), 1);
    chk("busy_armed", 32'(busy), 1);
    start_evt = 1'b1;
    start_fine = 8'd150;
    tick();
    start_evt = 1'b0;
    chk("en_start_after_start", 32'(en_start), 0);
    chk("en_stop_after_start", 32'(en_stop), 1);
    repeat (2) tick();
    chk("no_valid_before_stop", 32'(res_valid), 0);
    stop_evt = 1'b1;
    stop_fine = 8'd40;
    push_exp(3, 710, 1'b0);
    tick();
    stop_evt = 1'b0;
    chk("valid_after_stop", 32'(res_valid), 1);
    // Simultaneous start/stop in DONE counts once per cycle.
    start_evt = 1'b1;
    stop_evt = 1'b1;
    repeat (2) tick();
    start_evt = 1'b0;
    stop_evt = 1'b0;
    chk("missed_dual", 32'(missed_cnt), 2);
    consume();
    chk("valid_drop", 32'(res_valid), 0);
    chk("idle_en_start", 32'(en_start), 0);

    // Fine codes reduce a one-cycle interval but it stays signed-correct.
    push_exp(1, 20, 1'b0);
    measure(8'd10, 8'd190, 1, 1'b0);
    consume();
    push_exp(1, 10, 1'b0);
    measure(8'd0, 8'd190, 1, 1'b0);
    consume();
    push_exp(1, -55, 1'b0);
    measure(8'd0, 8'd255, 1, 1'b0);
    consume();
    // stop_evt alongside start_evt in ARMED is ignored: 2*200 + 20 - 20 = 400
    push_exp(2, 400, 1'b0);
    measure(8'd20, 8'd20, 2, 1'b1);
    consume();

    // Timeout with no stop.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    start_evt = 1'b1;
    start_fine = 8'd7;
    tick();
    start_evt = 1'b0;
    repeat (999) tick();
    chk("no_timeout_early", 32'(res_valid), 0);
    push_exp(1000, 0, 1'b1);
    tick();
    chk("timeout_valid", 32'(res_valid), 1);
    consume();
    // Stop on the timeout cycle wins: 1000*200 + 7 - 30 = 199977
    push_exp(1000, 199977, 1'b0);
    measure(8'd7, 8'd30, 1000, 1'b0);
    consume();

    // Back-pressure with saturating missed count, then auto-rearm hand-off.
    push_exp(1, 200, 1'b0);
    measure(8'd50, 8'd50, 1, 1'b0);
    stable = 1'b1;
    start_evt = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!res_valid || res_coarse != 16'd1 || res_interval != W'(200)) stable = 1'b0;
    end
    start_evt = 1'b0;
    chk("result_stable", 32'(stable), 1);
    chk("missed_sat", 32'(missed_cnt), 255);
    auto_rearm = 1'b1;
    consume();
    auto_rearm = 1'b0;
    chk("rearm_en_start", 32'(en_start), 1);
    chk("rearm_valid_low", 32'(res_valid), 0);

    // Abort while RUNNING.
    start_evt = 1'b1;
    start_fine = 8'd3;
    tick();
    start_evt = 1'b0;
    chk("running_en_stop", 32'(en_stop), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_en_stop", 32'(en_stop), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (3) tick();
    chk("abort_no_valid", 32'(res_valid), 0);
    chk("abort_missed_kept", 32'(missed_cnt), 255);

    // Reset in DONE clears everything immediately; this result is never consumed.
    measure(8'd1, 8'd1, 1, 1'b0);
    chk("done_before_reset", 32'(res_valid), 1);
    reset = 1'b1;
    #1;
    chk("reset_valid", 32'(res_valid), 0);
    chk("reset_coarse", 32'(res_coarse), 0);
    chk("reset_interval", 32'(res_interval), 0);
    chk("reset_missed", 32'(missed_cnt), 0);
    chk("reset_en", 32'({en_start, en_stop, busy, res_timeout}), 0);
    #10;
    reset = 1'b0;
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
